// File: rtl/matrix_stream_buffer_pkg.sv
// Shared types and elaboration-time helpers for the matrix stream buffer.
package matrix_stream_buffer_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

    function automatic int calc_beats(input int rows, input int cols, input int lanes);
        return (rows * cols + lanes - 1) / lanes;
    endfunction

    function automatic int calc_last_n(input int rows, input int cols, input int lanes);
        return rows * cols - (calc_beats(rows, cols, lanes) - 1) * lanes;
    endfunction

    // Index width that stays legal for a single-entry dimension.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matrix_pos_gen.sv
// Fill-position generator: holds the beat-start (row,col) and expands it into
// LANES consecutive positions in the selected order, plus a lane-valid mask.
module matrix_pos_gen
    import matrix_stream_buffer_pkg::*;
#(
    parameter int ROWS  = 13,
    parameter int COLS  = 13,
    parameter int LANES = 4,
    parameter int RW    = idx_w(ROWS),
    parameter int CW    = idx_w(COLS)
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        clear,
    input  logic                        advance,
    input  logic                        col_major,
    input  logic                        last_beat,
    output logic [LANES-1:0][RW-1:0]    lane_row,
    output logic [LANES-1:0][CW-1:0]    lane_col,
    output logic [LANES-1:0]            lane_vld
);

    localparam int LAST_N = calc_last_n(ROWS, COLS, LANES);

    logic [RW-1:0] base_row, row_w;
    logic [CW-1:0] base_col, col_w;

    // Walk the lanes with wrap-around increments; after the loop row_w/col_w
    // hold the start position of the following beat. Both axes wrap, so lanes
    // past the end of the matrix alias real cells and must be masked.
    always_comb begin
        row_w    = base_row;
        col_w    = base_col;
        lane_row = '0;
        lane_col = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_row[i] = row_w;
            lane_col[i] = col_w;
            if (!col_major) begin
                if (col_w == CW'(COLS - 1)) begin
                    col_w = '0;
                    row_w = (row_w == RW'(ROWS - 1)) ? '0 : row_w + 1'b1;
                end else begin
                    col_w = col_w + 1'b1;
                end
            end else begin
                if (row_w == RW'(ROWS - 1)) begin
                    row_w = '0;
                    col_w = (col_w == CW'(COLS - 1)) ? '0 : col_w + 1'b1;
                end else begin
                    row_w = row_w + 1'b1;
                end
            end
        end
    end

    always_comb begin
        lane_vld = '0;
        for (int i = 0; i < LANES; i++)
            lane_vld[i] = !last_beat || (i < LAST_N);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            base_row <= '0;
            base_col <= '0;
        end else if (clear) begin
            base_row <= '0;
            base_col <= '0;
        end else if (advance) begin
            base_row <= row_w;
            base_col <= col_w;
        end
    end

endmodule

// File: rtl/matrix_stream_buffer.sv
// Streams LANES elements per beat into a ROWS x COLS register matrix and
// exposes the whole matrix in parallel, with fill-complete status.
module matrix_stream_buffer
    import matrix_stream_buffer_pkg::*;
#(
    parameter int ROWS  = 13,
    parameter int COLS  = 13,
    parameter int WIDTH = 8,
    parameter int LANES = 4
) (
    input  logic                                     clock,
    input  logic                                     reset_n,
    input  logic                                     start,
    input  logic                                     col_major,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [LANES-1:0][WIDTH-1:0]              in_data,
    output logic [ROWS-1:0][COLS-1:0][WIDTH-1:0]     out_mat,
    output logic                                     full,
    output logic                                     done,
    output logic [$clog2(calc_beats(ROWS, COLS, LANES)+1)-1:0] beat_cnt
);

    localparam int BEATS = calc_beats(ROWS, COLS, LANES);
    localparam int BCW   = $clog2(BEATS + 1);
    localparam int RW    = idx_w(ROWS);
    localparam int CW    = idx_w(COLS);

    state_t state, state_nxt;
    logic   order;
    logic   accept, final_beat;

    logic [LANES-1:0][RW-1:0] lane_row;
    logic [LANES-1:0][CW-1:0] lane_col;
    logic [LANES-1:0]         lane_vld;

    assign in_ready   = (state == LOAD) && !start;
    assign accept     = in_valid && in_ready;
    assign final_beat = (beat_cnt == BCW'(BEATS - 1));
    assign full       = (state == FULL);

    always_comb begin
        state_nxt = state;
        if (start)
            state_nxt = LOAD;
        else if (accept && final_beat)
            state_nxt = FULL;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            beat_cnt <= '0;
            done     <= 1'b0;
            order    <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= accept && final_beat;
            if (start) begin
                beat_cnt <= '0;
                order    <= col_major;
            end else if (accept) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    matrix_pos_gen #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .LANES (LANES),
        .RW    (RW),
        .CW    (CW)
    ) u_pos (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (start),
        .advance   (accept),
        .col_major (order),
        .last_beat (final_beat),
        .lane_row  (lane_row),
        .lane_col  (lane_col),
        .lane_vld  (lane_vld)
    );

    // Each cell decodes whether some valid lane targets it this beat.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic             hit;
            logic [WIDTH-1:0] wdat, elem_q;

            always_comb begin
                hit  = 1'b0;
                wdat = '0;
                for (int i = 0; i < LANES; i++) begin
                    if (lane_vld[i] && lane_row[i] == RW'(r) && lane_col[i] == CW'(c)) begin
                        hit  = 1'b1;
                        wdat = in_data[i];
                    end
                end
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n)
                    elem_q <= '0;
                else if (accept && hit)
                    elem_q <= wdat;
            end

            assign out_mat[r][c] = elem_q;
        end
    end

endmodule

// File: tb/tb_matrix_stream_buffer.sv
// Bench for matrix_stream_buffer: default 13x13 instance checked against an
// index-arithmetic model every cycle, plus a 3x5 instance with literal checks.
module tb_matrix_stream_buffer;

    localparam int R  = 13, C  = 13, W  = 8,  L  = 4;
    localparam int NB = (R * C + L - 1) / L;
    localparam int SR = 3,  SC = 5,  SW = 16, SL = 4;
    localparam int SNB = (SR * SC + SL - 1) / SL;

    typedef logic [L-1:0][W-1:0]   beat_t;
    typedef logic [SL-1:0][SW-1:0] sbeat_t;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    logic                          start, col_major, in_valid, in_ready, full, done;
    beat_t                         in_data;
    logic [R-1:0][C-1:0][W-1:0]    out_mat;
    logic [$clog2(NB+1)-1:0]       beat_cnt;

    logic                          s_start, s_col_major, s_in_valid, s_in_ready, s_full, s_done;
    sbeat_t                        s_in_data;
    logic [SR-1:0][SC-1:0][SW-1:0] s_out_mat;
    logic [$clog2(SNB+1)-1:0]      s_beat_cnt;

    matrix_stream_buffer dut (
        .clock(clock), .reset_n(reset_n), .start(start), .col_major(col_major),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .out_mat(out_mat),
        .full(full), .done(done), .beat_cnt(beat_cnt)
    );

    matrix_stream_buffer #(.ROWS(SR), .COLS(SC), .WIDTH(SW), .LANES(SL)) dut_s (
        .clock(clock), .reset_n(reset_n), .start(s_start), .col_major(s_col_major),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .out_mat(s_out_mat),
        .full(s_full), .done(s_done), .beat_cnt(s_beat_cnt)
    );

    // Model: element k of the fill lands at (k/C, k%C) or (k%R, k/R).
    logic [W-1:0] m_mat [R][C];
    int  m_state;           // 0 idle, 1 loading, 2 full
    int  m_cnt, m_k;
    bit  m_done, m_order;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++)
                    m_mat[r][c] = '0;
            m_state = 0; m_cnt = 0; m_done = 0; m_order = 0;
        end else begin
            m_done = 0;
            if (start) begin
                m_state = 1; m_cnt = 0; m_order = col_major;
            end else if (m_state == 1 && in_valid) begin
                for (int i = 0; i < L; i++) begin
                    m_k = m_cnt * L + i;
                    if (m_k < R * C) begin
                        if (!m_order) m_mat[m_k / C][m_k % C] = in_data[i];
                        else          m_mat[m_k % R][m_k / R] = in_data[i];
                    end
                end
                m_cnt++;
                if (m_cnt == NB) begin
                    m_state = 2; m_done = 1;
                end
            end
        end
    end

    int checks = 0, errors = 0;
    int done_cnt = 0, s_done_cnt = 0;
    bit rdy_m, rdy_s;

    task automatic check(input string nm, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic cmp_model();
        int mism;
        mism = 0;
        check("full", full, m_state == 2);
        check("done", done, m_done);
        check("beat_cnt", beat_cnt, m_cnt);
        check("in_ready", in_ready, m_state == 1 && !start);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                if (out_mat[r][c] !== m_mat[r][c]) mism++;
        check("out_mat_vs_model", mism, 0);
        if (done)   done_cnt++;
        if (s_done) s_done_cnt++;
    endtask

    // Inputs change at posedge+1; outputs compared at negedge.
    task automatic tick();
        @(negedge clock);
        cmp_model();
        rdy_m = in_ready;
        rdy_s = s_in_ready;
        @(posedge clock);
        #1;
    endtask

    function automatic beat_t pat(input int b);
        beat_t d;
        for (int i = 0; i < L; i++) d[i] = W'(L * b + i);
        return d;
    endfunction

    function automatic sbeat_t s_pat(input int b);
        sbeat_t d;
        for (int i = 0; i < SL; i++) d[i] = SW'(100 + SL * b + i);
        return d;
    endfunction

    task automatic send(input beat_t d, input int gap);
        int n;
        n = 0;
        in_valid = 0;
        repeat (gap) tick();
        in_valid = 1;
        in_data  = d;
        do begin tick(); n++; end while (!rdy_m && n < 20);
        in_valid = 0;
        if (!rdy_m) check("send_timeout", 0, 1);
    endtask

    task automatic s_send(input sbeat_t d);
        int n;
        n = 0;
        s_in_valid = 1;
        s_in_data  = d;
        do begin tick(); n++; end while (!rdy_s && n < 20);
        s_in_valid = 0;
        if (!rdy_s) check("s_send_timeout", 0, 1);
    endtask

    task automatic do_start(input bit cm);
        start = 1; col_major = cm;
        tick();
        start = 0;
    endtask

    task automatic check_pattern(input string nm, input bit cm, input bit fill_aa);
        int mism, e;
        mism = 0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                e = fill_aa ? 8'hAA : (cm ? 13 * c + r : 13 * r + c);
                if (out_mat[r][c] != W'(e)) mism++;
            end
        check(nm, mism, 0);
    endtask

    int d0;

    initial begin
        reset_n = 1; start = 0; col_major = 0; in_valid = 0; in_data = '0;
        s_start = 0; s_col_major = 0; s_in_valid = 0; s_in_data = '0;
        #2 reset_n = 0;
        #1;
        check("rst_full", full, 0);
        check("rst_done", done, 0);
        check("rst_beat_cnt", beat_cnt, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_mat00", out_mat[0][0], 0);
        tick(); tick();
        reset_n = 1;
        tick();

        // 1: row-major fill
        d0 = done_cnt;
        do_start(0);
        for (int b = 0; b < NB; b++) send(pat(b), 0);
        tick(); tick();
        check("t1_mat_12_12", out_mat[12][12], 168);
        check("t1_mat_1_2", out_mat[1][2], 15);
        check("t1_mat_12_0", out_mat[12][0], 156);
        check("t1_mat_0_1_not_clobbered", out_mat[0][1], 1);
        check("t1_model_5_7", m_mat[5][7], 72);
        check("t1_full", full, 1);
        check("t1_beat_cnt", beat_cnt, 43);
        check("t1_done_pulses", done_cnt - d0, 1);
        check_pattern("t1_pattern", 0, 0);
        in_valid = 1; in_data = {L{8'hFF}};
        tick(); tick();
        in_valid = 0;
        check("t1_full_ignores_valid", out_mat[0][0], 0);

        // 2: column-major fill
        d0 = done_cnt;
        do_start(1);
        for (int b = 0; b < NB; b++) send(pat(b), 0);
        tick();
        check("t2_mat_12_12", out_mat[12][12], 168);
        check("t2_mat_2_1", out_mat[2][1], 15);
        check("t2_mat_0_1", out_mat[0][1], 13);
        check("t2_done_pulses", done_cnt - d0, 1);
        check_pattern("t2_pattern", 1, 0);

        // 3: gapped stream
        do_start(0);
        for (int b = 0; b < NB; b++) send(pat(b), int'($urandom_range(0, 3)));
        tick();
        check_pattern("t3_pattern", 0, 0);
        check("t3_beat_cnt", beat_cnt, 43);

        // 4: restart mid-fill, then full refill
        d0 = done_cnt;
        do_start(0);
        for (int b = 0; b < 20; b++) send(pat(b), 0);
        check("t4_no_done_at_20", done_cnt - d0, 0);
        start = 1; in_valid = 1; in_data = {L{8'hAA}};
        tick();
        start = 0; in_valid = 0;
        check("t4_ready_on_start", rdy_m, 0);
        check("t4_cnt_after_start", beat_cnt, 0);
        for (int b = 0; b < NB; b++) send({L{8'hAA}}, 0);
        tick();
        check_pattern("t4_all_aa", 0, 1);
        check("t4_done_pulses", done_cnt - d0, 1);

        // 4b: start collides with the final beat
        d0 = done_cnt;
        do_start(0);
        for (int b = 0; b < NB - 1; b++) send(pat(b), 0);
        start = 1; in_valid = 1; in_data = pat(NB - 1);
        tick();
        start = 0; in_valid = 0;
        tick();
        check("t4b_no_done", done_cnt - d0, 0);
        check("t4b_cnt", beat_cnt, 0);
        check("t4b_not_full", full, 0);
        check("t4b_mat_12_12_kept", out_mat[12][12], 8'hAA);

        // 5: async reset mid-fill
        do_start(0);
        for (int b = 0; b < 30; b++) send(pat(b), 0);
        #2 reset_n = 0;
        #1;
        check("t5_full", full, 0);
        check("t5_beat_cnt", beat_cnt, 0);
        check("t5_in_ready", in_ready, 0);
        check("t5_mat_1_2", out_mat[1][2], 0);
        tick();
        reset_n = 1;
        in_valid = 1; in_data = pat(5);
        tick(); tick();
        in_valid = 0;
        check("t5_idle_ready", rdy_m, 0);
        check("t5_idle_cnt", beat_cnt, 0);

        // 6: 3x5 instance, LAST_N = 3
        d0 = s_done_cnt;
        s_start = 1; s_col_major = 0;
        tick();
        s_start = 0;
        for (int b = 0; b < SNB; b++) s_send(s_pat(b));
        tick();
        check("t6_full", s_full, 1);
        check("t6_beat_cnt", s_beat_cnt, 4);
        check("t6_done_pulses", s_done_cnt - d0, 1);
        check("t6_mat_2_4", s_out_mat[2][4], 114);
        check("t6_mat_2_2", s_out_mat[2][2], 112);
        check("t6_mat_0_0", s_out_mat[0][0], 100);
        s_in_valid = 1; s_in_data = {SL{16'hFFFF}};
        tick();
        check("t6_extra_ready", rdy_s, 0);
        tick();
        s_in_valid = 0;
        check("t6_extra_cnt", s_beat_cnt, 4);
        check("t6_extra_mat_1_1", s_out_mat[1][1], 106);
        s_start = 1; s_col_major = 1;
        tick();
        s_start = 0;
        for (int b = 0; b < SNB; b++) s_send(s_pat(b));
        tick();
        check("t6c_mat_2_4", s_out_mat[2][4], 114);
        check("t6c_mat_1_3", s_out_mat[1][3], 110);
        check("t6c_mat_2_0", s_out_mat[2][0], 102);
        check("t6c_mat_0_1", s_out_mat[0][1], 103);
        check("t6c_mat_0_0", s_out_mat[0][0], 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
